// File: rtl/sa_pkg.sv
// Shared types for the systolic-array output path.
package sa_pkg;

  // Accumulator width shared with the PE.
  localparam int OC_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    CLEAR = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sa_drain_fifo.sv
// Capture FIFO for drained rows: {row_idx, payload} entries, registered head.
module sa_drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/sa_output_drain.sv
// Drains PE accumulators down the c-chain into a FIFO and streams them as rows.
module sa_output_drain
  import sa_pkg::*;
#(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int OC_W       = OC_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic [N_COLS*OC_W-1:0]     i_col_c,
  output logic                       o_shift_en,
  output logic                       o_reg_clear,
  output logic [N_COLS*OC_W-1:0]     o_data,
  output logic [$clog2(N_ROWS)-1:0]  o_row_idx,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int RW = $clog2(N_ROWS);
  localparam int DW = N_COLS * OC_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_t  state;
  logic [RW-1:0] cap_cnt;
  logic [RW-1:0] cap_row;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Shift only while there is room; depends on registered occupancy only,
  // so a pop in the same cycle never opens a slot for a push.
  assign o_shift_en = (state == SHIFT) && !fifo_full;
  assign push       = o_shift_en;
  assign o_valid    = !fifo_empty;
  assign pop        = o_valid && i_ready;
  // Bottom row leaves the chain first.
  assign cap_row    = RW'(N_ROWS - 1) - cap_cnt;

  sa_drain_fifo #(
    .W     (RW + DW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .push   (push),
    .pop    (pop),
    .wdata  ({cap_row, i_col_c}),
    .rdata  ({o_row_idx, o_data}),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  // Drain sequencer with registered busy/done/clear outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      cap_cnt     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_reg_clear <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_reg_clear <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          state   <= SHIFT;
          cap_cnt <= '0;
          o_busy  <= 1'b1;
        end
        SHIFT: if (push) begin
          cap_cnt <= cap_cnt + 1'b1;
          if (cap_cnt == RW'(N_ROWS - 1)) state <= FLUSH;
        end
        // Leave once the FIFO is, or is about to be, empty.
        FLUSH: if (fifo_empty || (count == CW'(1) && pop)) begin
          state       <= CLEAR;
          o_done      <= 1'b1;
          o_reg_clear <= 1'b1;
        end
        CLEAR: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sa_output_drain.md
Name: sa_output_drain

Overview:
Output-side controller for the output-stationary systolic array. After a compute pass it shifts the PE accumulators down the c-chain one row per cycle, capturing the bottom-row values into a small FIFO. It presents them as a valid/ready row stream to the writeback path, stalling the chain shift on back-pressure, then pulses a register clear to the array.

Parameters:
N_ROWS, 4, array rows (beats per drain)
N_COLS, 4, array columns (accumulators per beat)
OC_W, 48, accumulator width per PE
FIFO_DEPTH, 4, capture FIFO entries (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_start  in  1  drain request pulse; sampled only in IDLE
i_col_c  in  N_COLS*OC_W  bottom-row PE o_c values, column 0 in LSBs
o_shift_en  out  1  chain shift enable to the array (drives PE pipeline enable during drain)
o_reg_clear  out  1  one-cycle clear pulse to all PEs after drain
o_data  out  N_COLS*OC_W  row beat payload
o_row_idx  out  $clog2(N_ROWS)  array row of current beat
o_valid  out  1  beat valid
i_ready  in  1  downstream accept
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse when drain completes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; row counter 0.
- FSM states: IDLE, SHIFT, FLUSH, CLEAR.
- IDLE -> SHIFT on i_start. i_start in any other state is ignored (no queuing).
- SHIFT:
  - o_shift_en = 1 iff registered FIFO count < FIFO_DEPTH.
  - o_shift_en does not depend combinationally on i_ready.
  - On each cycle with o_shift_en = 1, i_col_c is pushed with tag row = N_ROWS-1-k, where k is the 0-based capture count. The bottom row exits first.
  - After the N_ROWS-th capture -> FLUSH.
- FLUSH: o_shift_en = 0; wait until the FIFO is empty (after the last pop) -> CLEAR.
- CLEAR: o_reg_clear = 1 and o_done = 1 for exactly one cycle -> IDLE.
- Stream:
  - o_valid = FIFO not empty; o_data/o_row_idx = FIFO head, registered.
  - Transfer on o_valid & i_ready. Payload is held stable while o_valid & !i_ready.
  - Latency from capture to o_valid is 1 cycle.
- Simultaneous push and pop: count unchanged, data order preserved.
- When full, a pop in the same cycle does NOT enable a push; the push resumes next cycle.
- With i_ready held 1 and FIFO_DEPTH >= 2: drain takes N_ROWS shift cycles + 1 flush + 1 clear. i_start to o_done = N_ROWS+2 cycles.
- Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- Asynchronous reset mid-drain: immediate return to reset values, FIFO contents discarded, no o_reg_clear or o_done emitted.
- Data is passed through unmodified; no arithmetic on payload.

Decomposition:
- Shared package sa_pkg: drain_state_t enum (IDLE, SHIFT, FLUSH, CLEAR); default OC_W constant shared with the PE.
- Sub-module sa_drain_fifo: synchronous FIFO of {row_idx, N_COLS*OC_W}, with push/pop/full/empty/count ports and the same reset.
- FSM and row counter live in the top.

Test Plan:
- N_ROWS=4, FIFO_DEPTH=4, i_ready=1, i_col_c rows {0x11,0x22,0x33,0x44} (all columns) -> beats in order with o_row_idx 3,2,1,0; o_shift_en high 4 cycles; o_done and o_reg_clear at cycle 6 after i_start.
- i_ready=0 throughout drain, FIFO_DEPTH=2 -> exactly 2 captures, then o_shift_en=0 and o_data stable. Release i_ready -> remaining 2 rows captured, 4 beats delivered in order, o_done after last pop.
- Full FIFO with pop in the same cycle -> no push that cycle, push next cycle; count sequence 2,1,2 verified.
- i_start pulsed during SHIFT and FLUSH -> ignored; exactly one o_done; o_busy stays high until CLEAR completes.
- i_rstn asserted after 2 captures -> all outputs 0 immediately, no o_reg_clear. New i_start after release -> full 4-beat drain is correct.
- Random i_ready (50%) over 100 drains, N_COLS=4, OC_W=48 -> scoreboard matches every beat, and no beat drops or duplicates.
